// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Latency: command registered to the RAM at the accept edge; read data returns with rvalidX two cycles after accept.
// Backpressure: gntX is a combinational accept, and a requester holds its command until it is granted.
// Optional burst lock: define RAM_ARB_LOCK_EN to enable lockX with a MAX_BURST fairness cap.

module ram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    din0,
    input  logic [DATA_WIDTH-1:0]    din1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    // Round-robin pointer: names the requester that wins a tie.
    logic prio_q, prio_d;

    // Registered RAM command.
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;

    // Read tag pipeline: {valid, owner} per stage, stage 2 lines up with RAM read data.
    logic s1_vld_q, s1_vld_d, s1_own_q, s1_own_d;
    logic s2_vld_q, s2_own_q;

    // Winner of this cycle's arbitration.
    logic                     xfer;
    logic                     win;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_din;

    // Grant: a sole requester always wins, prio breaks ties, nothing is granted in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign xfer = gnt0 | gnt1;
    assign win  = gnt1;

    // Select the winning requester's command fields.
    always_comb begin
        sel_we   = win ? we1   : we0;
        sel_addr = win ? addr1 : addr0;
        sel_din  = win ? din1  : din0;
    end

    // Command register: load on accept; on idle cycles drop the write enable and hold address/data.
    always_comb begin
        wen_d  = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        if (xfer) begin
            wen_d  = sel_we;
            addr_d = sel_addr;
            din_d  = sel_din;
        end
    end

    // Tag stage 1 records accepted reads and who issued them.
    always_comb begin
        s1_vld_d = xfer & ~sel_we;
        s1_own_d = win;
    end

`ifdef RAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    // Consecutive locked grants to burst_own_q; zero means no burst in progress.
    logic [CW-1:0] burst_q, burst_d;
    logic          burst_own_q, burst_own_d;
    logic [CW-1:0] run;
    logic          win_lock;
    logic          other_req;

    // Priority update with lock: a locked winner keeps priority until its burst hits MAX_BURST while the other waits.
    always_comb begin
        prio_d      = prio_q;
        burst_d     = burst_q;
        burst_own_d = burst_own_q;
        win_lock    = win ? lock1 : lock0;
        other_req   = win ? req0 : req1;
        run         = CW'(1);
        if (xfer) begin
            if (burst_own_q == win && burst_q != '0) begin
                run = (burst_q >= CW'(MAX_BURST)) ? burst_q : burst_q + CW'(1);
            end
            if (win_lock) begin
                if (run >= CW'(MAX_BURST) && other_req) begin
                    prio_d  = ~win;
                    burst_d = '0;
                end else begin
                    prio_d      = win;
                    burst_d     = run;
                    burst_own_d = win;
                end
            end else begin
                prio_d  = ~win;
                burst_d = '0;
            end
        end else if (!(burst_own_q ? lock1 : lock0)) begin
            burst_d = '0;
        end
    end

    // Burst tracking state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_q     <= '0;
            burst_own_q <= 1'b0;
        end else begin
            burst_q     <= burst_d;
            burst_own_q <= burst_own_d;
        end
    end
`else
    logic unused_lock;
    localparam int UNUSED_MAX_BURST = MAX_BURST;
    assign unused_lock = lock0 | lock1;

    // Plain round-robin: after any transfer the other requester gets priority.
    always_comb begin
        prio_d = xfer ? ~win : prio_q;
    end
`endif

    // Arbiter, command and tag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q   <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_own_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_own_q <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            s1_vld_q <= s1_vld_d;
            s1_own_q <= s1_own_d;
            s2_vld_q <= s1_vld_q;
            s2_own_q <= s1_own_q;
        end
    end

    assign ram_wEn    = wen_q;
    assign ram_addr   = addr_q;
    assign ram_dataIn = din_q;
    assign rvalid0    = s2_vld_q & ~s2_own_q;
    assign rvalid1    = s2_vld_q & s2_own_q;
    assign rdata      = ram_dataOut;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, accept-order reference model, directed and random scenarios.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Define RAM_ARB_LOCK_EN to include the burst lock scenario.

module tb_ram_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, din0, din1;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_wEn;
    logic [7:0] rdata, ram_addr, ram_dataIn, ram_dataOut;

    ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write or registered read each cycle; unwritten words read as addr*17.
    logic [7:0] ram_mem [256];
    logic       ram_wr  [256];
    always @(posedge clk) begin
        if (ram_wEn) begin
            ram_mem[ram_addr] <= ram_dataIn;
            ram_wr[ram_addr]  <= 1'b1;
        end else begin
            ram_dataOut <= (ram_wr[ram_addr] === 1'b1) ? ram_mem[ram_addr] : 8'(ram_addr * 17);
        end
    end

    // Reference model state.
    typedef struct {bit own; logic [7:0] dat; int due;} rd_t;
    rd_t        exp_q[$];
    logic [7:0] ref_mem [256];
    bit         m_prio;
    int         m_run;
    bit         m_runown;
    int         m_cyc;
    logic       m_wen;
    logic [7:0] m_addr, m_din;
    logic       e_g0, e_g1, e_rv0, e_rv1;
    logic [7:0] e_rd;
    int         nvec, nfail;

    task automatic drive(input logic rn,
                         input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1, input logic l1);
        @(negedge clk);
        reset_n = rn;
        req0 = r0; we0 = w0; addr0 = a0; din0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; din1 = d1; lock1 = l1;
        #1;
    endtask

    // Expected outputs for the current cycle.
    task automatic model_eval();
        e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd = '0;
        if (reset_n) begin
            if (req0 && req1) begin
                if (m_prio) e_g1 = 1; else e_g0 = 1;
            end else if (req0) e_g0 = 1;
            else if (req1) e_g1 = 1;
            if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
                e_rv0 = !exp_q[0].own;
                e_rv1 = exp_q[0].own;
                e_rd  = exp_q[0].dat;
            end
        end
    endtask

    // Advance the model over the coming clock edge.
    task automatic model_commit();
        bit w, we, lk, oth;
        logic [7:0] a, d;
        if (!reset_n) begin
            exp_q.delete();
            m_prio = 0; m_run = 0; m_runown = 0;
            m_wen = 0; m_addr = '0; m_din = '0;
        end else begin
            if (e_rv0 || e_rv1) void'(exp_q.pop_front());
            if (e_g0 || e_g1) begin
                w  = e_g1;
                we = w ? we1 : we0;
                a  = w ? addr1 : addr0;
                d  = w ? din1 : din0;
                m_wen = we; m_addr = a; m_din = d;
                if (we) ref_mem[a] = d;
                else exp_q.push_back('{w, ref_mem[a], m_cyc + 2});
`ifdef RAM_ARB_LOCK_EN
                lk  = w ? lock1 : lock0;
                oth = w ? req0 : req1;
                if (lk) begin
                    m_run = (m_runown == w && m_run > 0) ? m_run + 1 : 1;
                    m_runown = w;
                    if (m_run >= MAX_BURST && oth) begin
                        m_prio = !w;
                        m_run  = 0;
                    end else m_prio = w;
                end else begin
                    m_prio = !w;
                    m_run  = 0;
                end
`else
                m_prio = !w;
`endif
            end else begin
                m_wen = 0;
`ifdef RAM_ARB_LOCK_EN
                if (!(m_runown ? lock1 : lock0)) m_run = 0;
`endif
            end
        end
        m_cyc++;
    endtask

    task automatic apply_reset();
        repeat (2) begin
            drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
            model_eval();
            model_commit();
        end
    endtask

    task automatic test_reset();
        drive(0, 1, 0, 8'h33, 8'h44, 0, 0, 0, 8'h00, 8'h00, 0);
        model_eval(); model_commit();
        drive(0, 1, 0, 8'h33, 8'h44, 0, 0, 0, 8'h00, 8'h00, 0);
        nvec++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_wEn} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_ctrl: gnt0 gnt1 rv0 rv1 wEn got %b%b%b%b%b want 00000", gnt0, gnt1, rvalid0, rvalid1, ram_wEn);
        end
        nvec++;
        if (ram_addr !== 8'h00 || ram_dataIn !== 8'h00) begin
            nfail++;
            $display("FAIL reset_ram: addr %h din %h want 00 00", ram_addr, ram_dataIn);
        end
        model_eval(); model_commit();
        drive(1, 1, 0, 8'h33, 8'h44, 0, 0, 0, 8'h00, 8'h00, 0);
        model_eval();
        nvec++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release: gnt0 %b gnt1 %b want 1 0", gnt0, gnt1);
        end
        model_commit();
    endtask

    task automatic test_single_write_read();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 0);
                1: drive(1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
                default: drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
            endcase
            model_eval();
            nvec++;
            if ({gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn} !== {e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din}) begin
                nfail++;
                $display("FAIL single cyc %0d: g0g1rv0rv1wEn/addr/din got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", i,
                         gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn, e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din);
            end
            if (e_rv0 || e_rv1) begin
                nvec++;
                if (rdata !== e_rd) begin
                    nfail++;
                    $display("FAIL single_rdata cyc %0d: got %h want %h", i, rdata, e_rd);
                end
            end
            if (i == 3) begin
                nvec++;
                if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 8'hA5) begin
                    nfail++;
                    $display("FAIL single_return: rv0 %b rv1 %b rdata %h want 1 0 a5", rvalid0, rvalid1, rdata);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, 1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h02, 8'h00, 0);
            else drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
            model_eval();
            nvec++;
            if ({gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn} !== {e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din}) begin
                nfail++;
                $display("FAIL contention cyc %0d: g0g1rv0rv1wEn/addr/din got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", i,
                         gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn, e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din);
            end
            if (e_rv0 || e_rv1) begin
                nvec++;
                if (rdata !== e_rd) begin
                    nfail++;
                    $display("FAIL contention_rdata cyc %0d: got %h want %h", i, rdata, e_rd);
                end
            end
            if (i < 4) begin
                nvec++;
                if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                    nfail++;
                    $display("FAIL contention_order cyc %0d: gnt0 %b gnt1 %b", i, gnt0, gnt1);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_write_then_read();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1, 0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h20, 8'h3C, 0);
                1: drive(1, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
                default: drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
            endcase
            model_eval();
            nvec++;
            if ({gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn} !== {e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din}) begin
                nfail++;
                $display("FAIL wr_rd cyc %0d: g0g1rv0rv1wEn/addr/din got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", i,
                         gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn, e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din);
            end
            if (i == 3) begin
                nvec++;
                if (rvalid0 !== 1'b1 || rdata !== 8'h3C) begin
                    nfail++;
                    $display("FAIL wr_rd_return: rv0 %b rdata %h want 1 3c", rvalid0, rdata);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1, 1, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        model_eval(); model_commit();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
            model_eval();
            nvec++;
            if ({rvalid0, rvalid1, e_rv0, e_rv1} !== 4'b0) begin
                nfail++;
                $display("FAIL reset_mid_read cyc %0d: rv0 %b rv1 %b want 0 0", i, rvalid0, rvalid1);
            end
            model_commit();
        end
    endtask

    task automatic test_random();
        logic r0, w0, l0, r1, w1, l1;
        logic [7:0] a0, d0, a1, d1;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1)); l0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1)); l1 = 1'($urandom_range(0, 1));
            a0 = 8'($urandom_range(0, 7)); a1 = 8'($urandom_range(0, 7));
            d0 = 8'($urandom); d1 = 8'($urandom);
            drive(1, r0, w0, a0, d0, l0, r1, w1, a1, d1, l1);
            model_eval();
            nvec++;
            if ({gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn} !== {e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din}) begin
                nfail++;
                $display("FAIL random cyc %0d: g0g1rv0rv1wEn/addr/din got %b%b%b%b%b %h %h want %b%b%b%b%b %h %h", i,
                         gnt0, gnt1, rvalid0, rvalid1, ram_wEn, ram_addr, ram_dataIn, e_g0, e_g1, e_rv0, e_rv1, m_wen, m_addr, m_din);
            end
            if (e_rv0 || e_rv1) begin
                nvec++;
                if (rdata !== e_rd) begin
                    nfail++;
                    $display("FAIL random_rdata cyc %0d: got %h want %h", i, rdata, e_rd);
                end
            end
            model_commit();
        end
    endtask

`ifdef RAM_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 8'h01, 8'h00, 1, 1, 0, 8'h02, 8'h00, 0);
            model_eval();
            nvec++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== {e_g0, e_g1, e_rv0, e_rv1}) begin
                nfail++;
                $display("FAIL lock cyc %0d: g0g1rv0rv1 got %b%b%b%b want %b%b%b%b", i,
                         gnt0, gnt1, rvalid0, rvalid1, e_g0, e_g1, e_rv0, e_rv1);
            end
            nvec++;
            if (gnt1 !== (i % 5 == 4) || gnt0 !== (i % 5 != 4)) begin
                nfail++;
                $display("FAIL lock_burst cyc %0d: gnt0 %b gnt1 %b", i, gnt0, gnt1);
            end
            model_commit();
        end
    endtask
`endif

    initial begin
        reset_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
        nvec = 0; nfail = 0; m_cyc = 0;
        m_prio = 0; m_run = 0; m_runown = 0; m_wen = 0; m_addr = '0; m_din = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 17);
        test_reset();
        test_single_write_read();
        test_contention();
        test_write_then_read();
        test_reset_mid_read();
        test_random();
`ifdef RAM_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
